// File: rtl/fifo_pkt_writer_if.sv
// rtl/fifo_pkt_writer_if.sv - flit stream and FIFO write-port interfaces for fifo_pkt_writer
//
// flit_if     : producer flit stream (in_valid/in_data/in_last/in_abort) with in_stop backpressure.
//               master = producer, slave = fifo_pkt_writer.
// fifo_wr_if  : FIFO write port (shift_in/d_in), write-pointer rewind (dec_wptr/wptr_value)
//               and almost_full status. master = fifo_pkt_writer, slave = async_fifo write side.

interface flit_if #(
    parameter int DSIZE = 18
) ();
    logic             in_valid;
    logic [DSIZE-1:0] in_data;
    logic             in_last;
    logic             in_abort;
    logic             in_stop;

    modport master (output in_valid, output in_data, output in_last, output in_abort, input in_stop);
    modport slave  (input in_valid, input in_data, input in_last, input in_abort, output in_stop);
endinterface

interface fifo_wr_if #(
    parameter int DSIZE = 18,
    parameter int ASIZE = 9
) ();
    logic             shift_in;
    logic [DSIZE-1:0] d_in;
    logic             dec_wptr;
    logic [ASIZE:0]   wptr_value;
    logic             almost_full;

    modport master (output shift_in, output d_in, output dec_wptr, output wptr_value, input almost_full);
    modport slave  (input shift_in, input d_in, input dec_wptr, input wptr_value, output almost_full);
endinterface

// File: rtl/fifo_pkt_writer.sv
// rtl/fifo_pkt_writer.sv - packet-granular write controller in front of async_fifo
//
// Accepts a flit stream and writes it into the FIFO one registered write per accepted flit.
// Aborted or over-length packets are removed again by rewinding the FIFO write pointer, so
// only complete packets stay in the FIFO.
//
// Ports:
//   clk        write clock (FIFO wclk)
//   res_n      asynchronous active-low reset (shared with FIFO wres_n)
//   flit       flit_if.slave: in_valid, in_data, in_last, in_abort in; in_stop out
//   fifo       fifo_wr_if.master: shift_in, d_in, dec_wptr, wptr_value out; almost_full in
//   pkt_done   1-cycle pulse together with the write of a packet's last flit
//   err_len    1-cycle pulse when a packet exceeds MAX_PKT flits
//   abort_cnt  saturating count of discarded packets

module fifo_pkt_writer #(
    parameter int DSIZE   = 18,
    parameter int ASIZE   = 9,
    parameter int MAX_PKT = 32
) (
    input  logic        clk,
    input  logic        res_n,
    flit_if.slave       flit,
    fifo_wr_if.master   fifo,
    output logic        pkt_done,
    output logic        err_len,
    output logic [15:0] abort_cnt
);

    typedef enum logic [1:0] {IDLE, PKT, REWIND, DROP} state_t;

    localparam logic [ASIZE:0] MAX_CNT = (ASIZE+1)'(MAX_PKT);
    localparam logic [ASIZE:0] CNT_ONE = {{ASIZE{1'b0}}, 1'b1};

    state_t         state;
    logic [ASIZE:0] pkt_cnt;
    logic           drop_next;   // REWIND was caused by a length error: swallow the rest of the packet
    logic           stop;
    logic           accept;
    logic [15:0]    abort_inc;

    // The write launched by the previous accept is still in flight when almost_full is seen,
    // which is why the FIFO threshold of one free entry is enough to avoid overflow.
    always_comb begin
        stop = 1'b0;
        case (state)
            IDLE, PKT: stop = fifo.almost_full;
            REWIND:    stop = 1'b1;
            default:   stop = 1'b0;
        endcase
    end

    assign flit.in_stop = stop;
    assign accept       = flit.in_valid && !stop;
    assign abort_inc    = (abort_cnt == 16'hFFFF) ? abort_cnt : abort_cnt + 16'd1;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state           <= IDLE;
            pkt_cnt         <= '0;
            drop_next       <= 1'b0;
            fifo.shift_in   <= 1'b0;
            fifo.d_in       <= '0;
            fifo.dec_wptr   <= 1'b0;
            fifo.wptr_value <= '0;
            pkt_done        <= 1'b0;
            err_len         <= 1'b0;
            abort_cnt       <= '0;
        end else begin
            fifo.shift_in   <= 1'b0;
            fifo.dec_wptr   <= 1'b0;
            fifo.wptr_value <= '0;
            pkt_done        <= 1'b0;
            err_len         <= 1'b0;

            case (state)
                IDLE, PKT: begin
                    if (accept) begin
                        if (flit.in_abort) begin
                            // Abort wins over last; nothing to rewind if no flit was written yet.
                            abort_cnt <= abort_inc;
                            pkt_cnt   <= '0;
                            drop_next <= 1'b0;
                            if (pkt_cnt != '0) begin
                                fifo.dec_wptr   <= 1'b1;
                                fifo.wptr_value <= pkt_cnt;
                                state           <= REWIND;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (pkt_cnt == MAX_CNT) begin
                            // One flit too many: drop the MAX_PKT flits already written. If this
                            // flit also ends the packet there is nothing left to swallow.
                            err_len         <= 1'b1;
                            abort_cnt       <= abort_inc;
                            pkt_cnt         <= '0;
                            fifo.dec_wptr   <= 1'b1;
                            fifo.wptr_value <= pkt_cnt;
                            drop_next       <= !flit.in_last;
                            state           <= REWIND;
                        end else begin
                            fifo.shift_in <= 1'b1;
                            fifo.d_in     <= flit.in_data;
                            if (flit.in_last) begin
                                pkt_cnt  <= '0;
                                pkt_done <= 1'b1;
                                state    <= IDLE;
                            end else begin
                                pkt_cnt <= pkt_cnt + CNT_ONE;
                                state   <= PKT;
                            end
                        end
                    end
                end
                REWIND: begin
                    state     <= drop_next ? DROP : IDLE;
                    drop_next <= 1'b0;
                end
                DROP: begin
                    if (flit.in_valid && (flit.in_last || flit.in_abort)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// tb/tb_fifo_pkt_writer.sv - self-checking bench for fifo_pkt_writer with a FIFO model
module tb_fifo_pkt_writer;

    localparam int DSIZE   = 18;
    localparam int ASIZE   = 3;
    localparam int MAX_PKT = 4;
    localparam int DEPTH   = 8;

    logic clk   = 1'b0;
    logic res_n = 1'b0;
    always #5 clk = ~clk;

    flit_if    #(.DSIZE(DSIZE))                flit ();
    fifo_wr_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) fw ();

    logic        pkt_done;
    logic        err_len;
    logic [15:0] abort_cnt;

    fifo_pkt_writer #(.DSIZE(DSIZE), .ASIZE(ASIZE), .MAX_PKT(MAX_PKT)) dut (
        .clk       (clk),
        .res_n     (res_n),
        .flit      (flit),
        .fifo      (fw),
        .pkt_done  (pkt_done),
        .err_len   (err_len),
        .abort_cnt (abort_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // FIFO write-side model: circular buffer with rewind, read port driven by the bench.
    logic [DSIZE-1:0] mem [DEPTH];
    int               wrp, rdp, cnt;
    logic             ovf;
    logic             rd = 1'b0;
    logic [DSIZE-1:0] rd_data;
    logic             af_force = 1'b0;

    assign fw.almost_full = af_force || ((DEPTH - cnt) <= 1);

    always @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wrp <= 0; rdp <= 0; cnt <= 0; ovf <= 1'b0; rd_data <= '0;
        end else begin
            if (fw.shift_in) begin
                if (cnt >= DEPTH) ovf <= 1'b1;
                mem[wrp] <= fw.d_in;
                wrp      <= (wrp + 1) % DEPTH;
            end
            if (rd && cnt > 0) begin
                rd_data <= mem[rdp];
                rdp     <= (rdp + 1) % DEPTH;
            end
            if (fw.dec_wptr) begin
                if (int'(fw.wptr_value) > cnt) ovf <= 1'b1;
                wrp <= (wrp + DEPTH - int'(fw.wptr_value)) % DEPTH;
            end
            cnt <= cnt + (fw.shift_in ? 1 : 0) - ((rd && cnt > 0) ? 1 : 0)
                       - (fw.dec_wptr ? int'(fw.wptr_value) : 0);
        end
    end

    // Event counters sampled mid-cycle; pulses wider than one cycle count more than once.
    int             n_shift = 0, n_done = 0, n_err = 0, n_dec = 0, ovl_err = 0, wv_err = 0;
    logic [ASIZE:0] last_wv = '0;
    always @(negedge clk) begin
        if (res_n) begin
            n_shift <= n_shift + int'(fw.shift_in);
            n_done  <= n_done + int'(pkt_done);
            n_err   <= n_err + int'(err_len);
            n_dec   <= n_dec + int'(fw.dec_wptr);
            if (fw.dec_wptr) last_wv <= fw.wptr_value;
            if (fw.dec_wptr && fw.shift_in) ovl_err <= ovl_err + 1;
            if (!fw.dec_wptr && fw.wptr_value != '0) wv_err <= wv_err + 1;
        end
    end

    logic [DSIZE-1:0] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        flit.in_valid = 1'b0; flit.in_last = 1'b0; flit.in_abort = 1'b0; flit.in_data = '0;
    endtask

    task automatic send(input logic [DSIZE-1:0] d, input logic l, input logic a, input logic keep);
        int t = 0;
        @(negedge clk);
        flit.in_valid = 1'b1; flit.in_data = d; flit.in_last = l; flit.in_abort = a;
        #1;
        while (flit.in_stop && t < 40) begin
            @(negedge clk); #1; t++;
        end
        chk("send_accept_timeout", (t >= 40) ? 32'd1 : 32'd0, 32'd0);
        if (t < 40 && keep) exp_q.push_back(d);
        @(posedge clk); #1;
    endtask

    task automatic drain(input string nm);
        int t = 0;
        logic [31:0] exp_d;
        while (cnt > 0 && t < 40) begin
            @(negedge clk); rd = 1'b1;
            @(posedge clk); #1; rd = 1'b0;
            exp_d = (exp_q.size() > 0) ? {14'd0, exp_q.pop_front()} : 32'hFFFF_FFFF;
            chk({nm, "_data"}, {14'd0, rd_data}, exp_d);
            t++;
        end
        chk({nm, "_left_expected"}, exp_q.size(), 32'd0);
        chk({nm, "_fifo_empty"}, cnt, 32'd0);
    endtask

    typedef struct {
        logic             v, l, a, af;
        logic [DSIZE-1:0] d;
        logic             keep;
        logic             stop, sh, done, dec;
        logic [ASIZE:0]   wv;
        logic             err;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic l, input logic a, input logic af,
                                input logic [DSIZE-1:0] d, input logic keep, input logic stop,
                                input logic sh, input logic done, input logic dec,
                                input logic [ASIZE:0] wv, input logic err);
        vec_t r;
        r.v = v; r.l = l; r.a = a; r.af = af; r.d = d; r.keep = keep;
        r.stop = stop; r.sh = sh; r.done = done; r.dec = dec; r.wv = wv; r.err = err;
        return r;
    endfunction

    vec_t tbl [15];
    int   s_shift, s_done, s_err, s_dec, k;

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        //          v  l  a  af d        keep stop sh done dec wv err
        tbl[0]  = mk(1, 0, 0, 0, 18'h101, 1,   0,   1, 0,   0,  0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 18'h102, 1,   0,   1, 0,   0,  0, 0);
        tbl[2]  = mk(1, 1, 0, 0, 18'h103, 1,   0,   1, 1,   0,  0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 18'h000, 0,   0,   0, 0,   0,  0, 0);
        tbl[4]  = mk(1, 0, 0, 0, 18'h201, 0,   0,   1, 0,   0,  0, 0);
        tbl[5]  = mk(1, 0, 0, 0, 18'h202, 0,   0,   1, 0,   0,  0, 0);
        tbl[6]  = mk(1, 0, 0, 0, 18'h203, 0,   0,   1, 0,   0,  0, 0);
        tbl[7]  = mk(1, 0, 0, 0, 18'h204, 0,   0,   1, 0,   0,  0, 0);
        tbl[8]  = mk(1, 0, 1, 0, 18'h2FF, 0,   0,   0, 0,   1,  4, 0);
        tbl[9]  = mk(0, 0, 0, 0, 18'h000, 0,   1,   0, 0,   0,  0, 0);
        tbl[10] = mk(1, 1, 1, 0, 18'h3FF, 0,   0,   0, 0,   0,  0, 0);
        tbl[11] = mk(0, 0, 0, 0, 18'h000, 0,   0,   0, 0,   0,  0, 0);
        tbl[12] = mk(1, 1, 0, 1, 18'h401, 0,   1,   0, 0,   0,  0, 0);
        tbl[13] = mk(1, 1, 0, 0, 18'h401, 1,   0,   1, 1,   0,  0, 0);
        tbl[14] = mk(0, 0, 0, 0, 18'h000, 0,   0,   0, 0,   0,  0, 0);

        flit.in_valid = 1'b0; flit.in_data = '0; flit.in_last = 1'b0; flit.in_abort = 1'b0;

        // Reset state
        #12;
        chk("rst_shift_in", fw.shift_in, 0);
        chk("rst_d_in", fw.d_in, 0);
        chk("rst_dec_wptr", fw.dec_wptr, 0);
        chk("rst_wptr_value", fw.wptr_value, 0);
        chk("rst_pkt_done", pkt_done, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_abort_cnt", abort_cnt, 0);
        chk("rst_in_stop", flit.in_stop, 0);
        @(negedge clk); res_n = 1'b1;

        // Cycle-exact vectors: 3-flit packet, abort after 4 flits, abort on first flit, stall
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            flit.in_valid = tbl[i].v; flit.in_data = tbl[i].d;
            flit.in_last  = tbl[i].l; flit.in_abort = tbl[i].a; af_force = tbl[i].af;
            #1;
            chk($sformatf("v%0d_in_stop", i), flit.in_stop, tbl[i].stop);
            if (tbl[i].keep) exp_q.push_back(tbl[i].d);
            @(posedge clk); #1;
            chk($sformatf("v%0d_shift_in", i), fw.shift_in, tbl[i].sh);
            chk($sformatf("v%0d_pkt_done", i), pkt_done, tbl[i].done);
            chk($sformatf("v%0d_dec_wptr", i), fw.dec_wptr, tbl[i].dec);
            chk($sformatf("v%0d_wptr_value", i), fw.wptr_value, tbl[i].wv);
            chk($sformatf("v%0d_err_len", i), err_len, tbl[i].err);
            if (tbl[i].sh) chk($sformatf("v%0d_d_in", i), fw.d_in, tbl[i].d);
        end
        af_force = 1'b0;
        idle();
        chk("tbl_abort_cnt", abort_cnt, 2);
        drain("tbl");

        // Over-length packet: 6 flits with MAX_PKT=4, then a normal 2-flit packet
        s_shift = n_shift; s_done = n_done; s_err = n_err; s_dec = n_dec;
        for (int i = 1; i <= 6; i++) send(18'h600 + DSIZE'(i), (i == 6), 1'b0, 1'b0);
        send(18'h701, 1'b0, 1'b0, 1'b1);
        send(18'h702, 1'b1, 1'b0, 1'b1);
        idle();
        repeat (3) @(negedge clk);
        chk("maxpkt_writes", n_shift - s_shift, 6);
        chk("maxpkt_err_len", n_err - s_err, 1);
        chk("maxpkt_dec_wptr", n_dec - s_dec, 1);
        chk("maxpkt_wptr_value", last_wv, MAX_PKT);
        chk("maxpkt_pkt_done", n_done - s_done, 1);
        chk("maxpkt_abort_cnt", abort_cnt, 3);
        drain("maxpkt");

        // Fill without reads: writes must stop at almost_full and land exactly on full
        s_shift = n_shift;
        k = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            flit.in_valid = 1'b1; flit.in_data = 18'h500 + DSIZE'(k);
            flit.in_last = (k % 4 == 3); flit.in_abort = 1'b0;
            #1;
            if (!flit.in_stop) begin
                exp_q.push_back(flit.in_data);
                k++;
            end
            @(posedge clk);
        end
        idle();
        repeat (2) @(negedge clk);
        chk("fill_accepted", k, DEPTH);
        chk("fill_writes", n_shift - s_shift, DEPTH);
        chk("fill_level", cnt, DEPTH);
        chk("fill_overflow", ovf, 0);
        chk("fill_in_stop", flit.in_stop, 1);
        drain("fill");

        // Reset in the middle of a packet
        send(18'h801, 1'b0, 1'b0, 1'b0);
        send(18'h802, 1'b0, 1'b0, 1'b0);
        #2 res_n = 1'b0;
        flit.in_valid = 1'b0; flit.in_last = 1'b0; flit.in_abort = 1'b0;
        #1;
        chk("midrst_shift_in", fw.shift_in, 0);
        chk("midrst_d_in", fw.d_in, 0);
        chk("midrst_dec_wptr", fw.dec_wptr, 0);
        chk("midrst_abort_cnt", abort_cnt, 0);
        @(negedge clk); res_n = 1'b1;
        s_shift = n_shift; s_done = n_done; s_dec = n_dec;
        send(18'h901, 1'b1, 1'b0, 1'b1);
        idle();
        repeat (2) @(negedge clk);
        chk("postrst_writes", n_shift - s_shift, 1);
        chk("postrst_pkt_done", n_done - s_done, 1);
        chk("postrst_dec_wptr", n_dec - s_dec, 0);
        drain("postrst");

        chk("dec_shift_overlap", ovl_err, 0);
        chk("wptr_value_idle_zero", wv_err, 0);
        chk("fifo_overflow_or_underflow", ovf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
